// File: rtl/bcd_to_c1.sv
// Sequential signed packed-BCD to 16-bit one's-complement converter.
// One digit per clock, most significant first, by multiply-by-10-and-add.
module bcd_to_c1 #(
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   BCD_in,
    input  logic                  sign_in,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           Dec_out,
    output logic                  err
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DIGITS - 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t              state, state_nxt;
    logic [4*DIGITS-1:0] bcd_q;
    logic                sign_q;
    logic [16:0]         acc;
    logic [CNT_W-1:0]    cnt;
    logic                inv, ovf;

    logic [3:0]          dig;
    logic [16:0]         acc_nxt;
    logic                inv_nxt, ovf_nxt;
    logic                last;

    // Returns {err, Dec_out}; negative zero collapses to +0.
    function automatic logic [16:0] format_c1(input logic [14:0] mag,
                                              input logic neg,
                                              input logic bad);
        if (bad)
            return {1'b1, 16'h0000};
        if (mag == 15'd0)
            return 17'h00000;
        if (neg)
            return {1'b0, 1'b1, ~mag};
        return {1'b0, 1'b0, mag};
    endfunction

    always_comb begin
        dig     = 4'(bcd_q >> {cnt, 2'b00});
        acc_nxt = acc * 17'd10 + {13'd0, dig};
        inv_nxt = inv | (dig > 4'd9);
        ovf_nxt = ovf | (acc_nxt > 17'd32767);
        last    = (cnt == '0);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONV;
            CONV:    if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    assign busy = (state == CONV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q   <= '0;
            sign_q  <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            inv     <= 1'b0;
            ovf     <= 1'b0;
            done    <= 1'b0;
            Dec_out <= 16'h0000;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    bcd_q  <= BCD_in;
                    sign_q <= sign_in;
                    acc    <= '0;
                    cnt    <= CNT_TOP;
                    inv    <= 1'b0;
                    ovf    <= 1'b0;
                end
            end else begin
                acc <= acc_nxt;
                inv <= inv_nxt;
                ovf <= ovf_nxt;
                if (last) begin
                    {err, Dec_out} <= format_c1(acc_nxt[14:0], sign_q, inv_nxt | ovf_nxt);
                    done           <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_to_c1.sv
// Scoreboard bench for bcd_to_c1: expectations queued at start, checked on done.
module tb_bcd_to_c1;

    localparam int DIGITS = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [4*DIGITS-1:0] BCD_in = '0;
    logic                sign_in = 1'b0;
    logic                busy, done, err;
    logic [15:0]         Dec_out;

    typedef struct packed {
        logic [15:0] dec;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc[$];

    bcd_to_c1 #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .BCD_in(BCD_in),
        .sign_in(sign_in), .busy(busy), .done(done), .Dec_out(Dec_out), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent reference: decimal magnitude, then one's-complement encode.
    function automatic exp_t model(input logic [4*DIGITS-1:0] bcd, input logic sgn);
        exp_t r;
        int   mag = 0;
        bit   bad = 0;
        logic [3:0] d;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            d = bcd[4*k +: 4];
            if (d > 9) bad = 1;
            mag = mag * 10 + int'(d);
        end
        if (bad || mag > 32767) r = '{dec: 16'h0000, err: 1'b1};
        else if (mag == 0)      r = '{dec: 16'h0000, err: 1'b0};
        else if (sgn)           r = '{dec: 16'hFFFF - 16'(mag), err: 1'b0};
        else                    r = '{dec: 16'(mag), err: 1'b0};
        return r;
    endfunction

    always @(posedge clk) begin
        cyc++;
        #1;
        if (done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            if (sb_q.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("dec_out", 32'(Dec_out), 32'(e.dec));
                chk("err", 32'(err), 32'(e.err));
            end
        end
    end

    // Starts a conversion now (caller is away from the edge) and waits for done.
    task automatic convert(input logic sgn, input logic [4*DIGITS-1:0] bcd, input exp_t e);
        int n;
        start   = 1'b1;
        sign_in = sgn;
        BCD_in  = bcd;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_e0", 32'(busy), 32'd1);
        BCD_in  = 20'(~bcd);
        sign_in = ~sgn;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
        if (!done) chk("done_timeout", 32'(n), 32'(DIGITS));
        else       chk("latency", 32'(n), 32'(DIGITS));
        chk("busy_at_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int dc;
        logic [4*DIGITS-1:0] rb;
        logic rs;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dec", 32'(Dec_out), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        convert(1'b0, 20'h12345, '{dec: 16'h3039, err: 1'b0});
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("dec_hold", 32'(Dec_out), 32'h3039);
        convert(1'b1, 20'h32767, '{dec: 16'h8000, err: 1'b0});
        convert(1'b0, 20'h32768, '{dec: 16'h0000, err: 1'b1});
        convert(1'b1, 20'h32768, '{dec: 16'h0000, err: 1'b1});
        convert(1'b0, 20'h1A000, '{dec: 16'h0000, err: 1'b1});
        convert(1'b0, 20'h99999, '{dec: 16'h0000, err: 1'b1});
        convert(1'b1, 20'h00000, '{dec: 16'h0000, err: 1'b0});
        convert(1'b0, 20'h32767, '{dec: 16'h7FFF, err: 1'b0});
        convert(1'b1, 20'h00001, '{dec: 16'hFFFE, err: 1'b0});

        // Mid-conversion reset with an ignored second start.
        @(negedge clk);
        dc = done_cnt;
        start = 1'b1; sign_in = 1'b0; BCD_in = 20'h00042;
        @(posedge clk); #1;                          // E0
        start = 1'b0;
        @(posedge clk); #1;                          // E1
        start = 1'b1; sign_in = 1'b1; BCD_in = 20'h00007;
        @(posedge clk); #1;                          // E2
        start = 1'b0;
        chk("busy_ignored_start", 32'(busy), 32'd1);
        @(posedge clk);                              // E3
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_dec", 32'(Dec_out), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        repeat (8) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt), 32'(dc));
        rst_n = 1'b1;
        @(negedge clk);
        convert(1'b0, 20'h00500, '{dec: 16'h01F4, err: 1'b0});

        // Back-to-back: second start issued in the done cycle.
        dc = done_cyc.size();
        convert(1'b0, 20'h00099, '{dec: 16'h0063, err: 1'b0});
        convert(1'b1, 20'h00100, '{dec: 16'hFF9B, err: 1'b0});
        if (done_cyc.size() == dc + 2)
            chk("b2b_spacing", 32'(done_cyc[dc+1] - done_cyc[dc]), 32'd6);
        else
            chk("b2b_done_count", 32'(done_cyc.size() - dc), 32'd2);

        for (int i = 0; i < 12; i++) begin
            rs = 1'($urandom_range(0, 1));
            for (int k = 0; k < DIGITS; k++)
                rb[4*k +: 4] = 4'($urandom_range(0, (i % 4 == 3) ? 15 : 9));
            if (i % 3 == 0) rb[4*(DIGITS-1) +: 4] = 4'($urandom_range(0, 3));
            convert(rs, rb, model(rb, rs));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_to_c1.md
# bcd_to_c1

Sequential converter from signed 5-digit packed BCD to a 16-bit one's-complement binary word. It accepts a sign bit and a BCD magnitude through a start/done handshake and processes one digit per clock, most significant first, using multiply-by-10-and-add. It is the return path of the datapath's binary-to-BCD display conversion: it turns keypad/BCD-entered operands back into the one's-complement range [-32767, 32767]. Invalid digits and out-of-range magnitudes are flagged, not wrapped.

## Interface
- DIGITS, 5, number of BCD digits in BCD_in; legal values 1..5.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- BCD_in  input  4*DIGITS  packed BCD magnitude; digit k is at [4k+3:4k], and digit 0 is least significant.
- sign_in  input  1  1 = negative; sampled together with BCD_in.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when Dec_out and err are updated.
- Dec_out  output  16  one's-complement result; holds its value until the next done.
- err  output  1  status of the last conversion; updated with done.

## Operation
- States: IDLE, CONV.
- Reset state: IDLE, with busy=0, done=0, Dec_out=16'h0000, err=0, and all internal registers cleared.
- IDLE, start=1:
  - Latch BCD_in and sign_in.
  - Set acc=0 (17-bit), cnt=DIGITS-1, and clear the sticky flags inv and ovf.
  - Go to CONV.
- IDLE, start=0: remain in IDLE.
- CONV, each cycle:
  - d = latched digit[cnt].
  - acc_next = acc*10 + d, computed in 17 bits. The maximum is 99999, so no wrap occurs.
  - inv |= (d > 9).
  - ovf |= (acc_next > 32767).
  - Decrement cnt.
- CONV, final digit (cnt==0): on the same edge, register the result, pulse done, and return to IDLE.
- Result formatting, applied in this order:
  - inv or ovf → err=1, Dec_out=16'h0000.
  - Magnitude 0 (either sign) → err=0, Dec_out=16'h0000. Negative zero is normalised to positive zero.
  - sign=0 → Dec_out={1'b0, acc[14:0]}.
  - sign=1 → Dec_out={1'b1, ~acc[14:0]}.
- start while busy=1: ignored. The latched operand is unaffected and no request is queued.
- BCD_in and sign_in changing during CONV: no effect.
- DIGITS<5: the upper digits do not exist, so the conversion takes fewer cycles.

## Timing
- Let E0 be the edge at which start is sampled in IDLE.
- Digits are consumed at edges E1..E_DIGITS.
- busy is high from E0 until E_DIGITS; it is low after E_DIGITS.
- done, Dec_out and err are registered at E_DIGITS. done is high for exactly one cycle and clears at E_DIGITS+1.
- Latency from E0 to done: DIGITS cycles (5 by default).
- A start asserted while done is high is accepted, because the state is IDLE. Maximum throughput is one conversion per DIGITS+1 cycles.
- rst_n low at any time, including mid-conversion: immediately return to reset values. No done is issued for the aborted conversion.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- sign_in=0, BCD_in=20'h12345, start for 1 cycle → busy for 5 cycles; done at E5 with Dec_out=16'h3039, err=0.
- sign_in=1, BCD_in=20'h32767 → Dec_out=16'h8000, err=0. Then sign_in=1, BCD_in=20'h00001 → Dec_out=16'hFFFE.
- BCD_in=20'h32768, either sign → err=1, Dec_out=16'h0000. BCD_in=20'h1A000 (invalid digit) → err=1, Dec_out=16'h0000.
- sign_in=1, BCD_in=20'h00000 → Dec_out=16'h0000, err=0.
- Reset and start rules:
  - start at E0; pulse start again at E2 with a different operand; assert rst_n=0 between E3 and E4 → the second start is ignored; outputs return to 0 immediately; no done pulse is seen.
  - After reset is released, a new conversion completes normally.
- Back-to-back conversions: start for 20'h00099, then start again in the done cycle for 20'h00100 with sign=1 → done pulses 6 cycles apart; results are 16'h0063, then 16'hFF9B.
